// File: rtl/addr_qual_arbiter.sv
// Two-requester address qualifier: a round-robin arbiter feeds one registered
// compare, results return on a valid/ready channel with saturating hit/miss stats.
module addr_qual_arbiter #(
   parameter int         AW          = 25,
   parameter logic [9:0] LIMIT_A_RST = 10'h055,
   parameter logic [9:0] LIMIT_B_RST = 10'h04C,
   parameter int         CW          = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_req_a,
   input  logic [AW-1:0] i_addr_a,
   input  logic          i_en_a,
   output logic          o_gnt_a,
   input  logic          i_req_b,
   input  logic [AW-1:0] i_addr_b,
   input  logic          i_en_b,
   output logic          o_gnt_b,
   output logic          o_rsp_valid,
   output logic          o_rsp_id,
   output logic          o_rsp_hit,
   input  logic          i_rsp_ready,
   input  logic          i_cfg_we,
   input  logic          i_cfg_sel,
   input  logic [9:0]    i_cfg_limit,
   input  logic          i_cnt_clr,
   output logic [CW-1:0] o_hit_cnt,
   output logic [CW-1:0] o_miss_cnt,
   output logic          o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t r_state;
   state_t w_state_next;

   logic w_capture;
   logic w_load_rsp;
   logic w_accept;
   logic w_pick_b;
   logic w_hit;

   logic               r_rr_ptr;
   logic [AW-14:0]     r_upper_q;
   logic [9:0]         r_index_q;
   logic               r_en_q;
   logic [9:0]         r_limit_q;
   logic               r_id_q;
   logic               r_gnt_a;
   logic               r_gnt_b;
   logic               r_rsp_valid;
   logic               r_rsp_id;
   logic               r_rsp_hit;

   logic [1:0][9:0]    w_limit;
   logic [1:0][CW-1:0] w_cnt;
   logic [AW-1:0]      w_addr_sel;

   // Bits [12:10] sit between the upper and index fields and never affect the result.
   logic w_unused;
   assign w_unused = ^{i_addr_a[12:10], i_addr_b[12:10]};

   // B wins only when A is absent, or when both ask and the pointer favours B.
   assign w_pick_b   = i_req_b & (~i_req_a | r_rr_ptr);
   assign w_addr_sel = w_pick_b ? i_addr_b : i_addr_a;

   assign w_hit = r_en_q & (r_upper_q == '0) & (r_index_q >= r_limit_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_load_rsp   = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_req_a | i_req_b) begin
               w_capture    = 1'b1;
               w_state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_load_rsp   = 1'b1;
            w_state_next = ST_RESP;
         end
         ST_RESP: begin
            if (i_rsp_ready) begin
               w_accept     = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_ptr    <= 1'b0;
         r_upper_q   <= '0;
         r_index_q   <= '0;
         r_en_q      <= 1'b0;
         r_limit_q   <= '0;
         r_id_q      <= 1'b0;
         r_gnt_a     <= 1'b0;
         r_gnt_b     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_hit   <= 1'b0;
      end else begin
         r_gnt_a <= w_capture & ~w_pick_b;
         r_gnt_b <= w_capture & w_pick_b;
         // The limit array still holds its pre-write value at this edge.
         if (w_capture) begin
            r_upper_q <= w_addr_sel[AW-1:13];
            r_index_q <= w_addr_sel[9:0];
            r_en_q    <= w_pick_b ? i_en_b : i_en_a;
            r_limit_q <= w_limit[w_pick_b];
            r_id_q    <= w_pick_b;
         end
         if (w_load_rsp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id_q;
            r_rsp_hit   <= w_hit;
         end else if (w_accept) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= ~r_id_q;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_limit
         localparam logic [9:0] LIM_RST = (gi == 0) ? LIMIT_A_RST : LIMIT_B_RST;
         logic [9:0] r_lim;
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_lim <= LIM_RST;
            end else if (i_cfg_we && (i_cfg_sel == 1'(gi))) begin
               r_lim <= i_cfg_limit;
            end
         end
         assign w_limit[gi] = r_lim;
      end

      // Counter 0 tallies hits, counter 1 tallies misses.
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic          w_inc;
         logic [CW-1:0] r_cnt;
         assign w_inc = w_accept & ((gi == 0) ? r_rsp_hit : ~r_rsp_hit);
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_cnt <= '0;
            end else if (i_cnt_clr) begin
               r_cnt <= '0;
            end else if (w_inc && (r_cnt != '1)) begin
               r_cnt <= r_cnt + CNT_ONE;
            end
         end
         assign w_cnt[gi] = r_cnt;
      end
   endgenerate

   assign o_gnt_a     = r_gnt_a;
   assign o_gnt_b     = r_gnt_b;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_id    = r_rsp_id;
   assign o_rsp_hit   = r_rsp_hit;
   assign o_hit_cnt   = w_cnt[0];
   assign o_miss_cnt  = w_cnt[1];
   assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_addr_qual_arbiter.sv
// Scoreboard bench for addr_qual_arbiter; a narrow-counter twin checks saturation.
module tb_addr_qual_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_a, en_a, req_b, en_b;
   logic [24:0] addr_a, addr_b;
   logic        rsp_ready, cfg_we, cfg_sel, cnt_clr;
   logic [9:0]  cfg_limit;

   logic        gnt_a, gnt_b, rsp_valid, rsp_id, rsp_hit, busy;
   logic [15:0] hit_cnt, miss_cnt;

   logic        s_gnt_a, s_gnt_b, s_rsp_valid, s_rsp_id, s_rsp_hit, s_busy;
   logic [1:0]  s_hit_cnt, s_miss_cnt;

   always #5 clk = ~clk;

   addr_qual_arbiter u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_a(req_a), .i_addr_a(addr_a), .i_en_a(en_a), .o_gnt_a(gnt_a),
      .i_req_b(req_b), .i_addr_b(addr_b), .i_en_b(en_b), .o_gnt_b(gnt_b),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_hit(rsp_hit),
      .i_rsp_ready(rsp_ready), .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel),
      .i_cfg_limit(cfg_limit), .i_cnt_clr(cnt_clr),
      .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt), .o_busy(busy)
   );

   addr_qual_arbiter #(.CW(2)) u_sat (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_a(req_a), .i_addr_a(addr_a), .i_en_a(en_a), .o_gnt_a(s_gnt_a),
      .i_req_b(req_b), .i_addr_b(addr_b), .i_en_b(en_b), .o_gnt_b(s_gnt_b),
      .o_rsp_valid(s_rsp_valid), .o_rsp_id(s_rsp_id), .o_rsp_hit(s_rsp_hit),
      .i_rsp_ready(rsp_ready), .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel),
      .i_cfg_limit(cfg_limit), .i_cnt_clr(cnt_clr),
      .o_hit_cnt(s_hit_cnt), .o_miss_cnt(s_miss_cnt), .o_busy(s_busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic       m_rr;
   logic [9:0] m_lim_a, m_lim_b;
   int         m_hit, m_miss, m_s_hit, m_s_miss;
   logic [1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic qual(input logic [24:0] a, input logic e, input logic [9:0] lim);
      logic [11:0] up;
      up = a[24:13];
      return e && (up == 12'h000) && (a[9:0] >= lim);
   endfunction

   function automatic int sat_inc(input int v, input int max);
      return (v >= max) ? max : v + 1;
   endfunction

   task automatic model_reset();
      m_rr = 1'b0; m_lim_a = 10'h055; m_lim_b = 10'h04C;
      m_hit = 0; m_miss = 0; m_s_hit = 0; m_s_miss = 0;
      exp_q.delete();
   endtask

   task automatic cfg_write(input logic sel, input logic [9:0] val);
      @(negedge clk);
      cfg_we = 1'b1; cfg_sel = sel; cfg_limit = val;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (sel) m_lim_b = val; else m_lim_a = val;
      $display("cfg  sel=%0d limit=%03h", sel, val);
   endtask

   task automatic txn(input logic ra, input logic [24:0] aa, input logic ea,
                      input logic rb, input logic [24:0] ab, input logic eb,
                      input bit hold, input int rdy_delay,
                      input bit do_cfg, input logic csel, input logic [9:0] cval,
                      input bit clr);
      logic       pick_b;
      logic [1:0] e;
      logic       seen;
      @(negedge clk);
      req_a = ra; addr_a = aa; en_a = ea;
      req_b = rb; addr_b = ab; en_b = eb;
      rsp_ready = (rdy_delay == 0);
      if (do_cfg) begin
         cfg_we = 1'b1; cfg_sel = csel; cfg_limit = cval;
      end
      pick_b = rb & (~ra | m_rr);
      exp_q.push_back({pick_b, pick_b ? qual(ab, eb, m_lim_b) : qual(aa, ea, m_lim_a)});
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (do_cfg) begin
         if (csel) m_lim_b = cval; else m_lim_a = cval;
      end
      check("gnt_a", gnt_a, !pick_b);
      check("gnt_b", gnt_b, pick_b);
      check("busy_grant", busy, 1);
      if (!hold) begin
         if (pick_b) req_b = 1'b0; else req_a = 1'b0;
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin seen = 1'b1; break; end
      end
      check("rsp_timeout", seen, 1);
      check("gnt_drop", {gnt_a, gnt_b}, 0);
      e = exp_q.pop_front();
      check("rsp_id", rsp_id, e[1]);
      check("rsp_hit", rsp_hit, e[0]);
      for (int i = 0; i < rdy_delay; i++) begin
         @(posedge clk); #1;
         check("stall_valid", rsp_valid, 1);
         check("stall_id", rsp_id, e[1]);
         check("stall_hit", rsp_hit, e[0]);
         check("stall_gnt", {gnt_a, gnt_b}, 0);
         check("stall_busy", busy, 1);
      end
      @(negedge clk);
      rsp_ready = 1'b1; cnt_clr = clr;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      if (clr) begin
         m_hit = 0; m_miss = 0; m_s_hit = 0; m_s_miss = 0;
      end else if (e[0]) begin
         m_hit = sat_inc(m_hit, 65535); m_s_hit = sat_inc(m_s_hit, 3);
      end else begin
         m_miss = sat_inc(m_miss, 65535); m_s_miss = sat_inc(m_s_miss, 3);
      end
      m_rr = ~e[1];
      check("valid_low", rsp_valid, 0);
      check("hit_cnt", hit_cnt, m_hit);
      check("miss_cnt", miss_cnt, m_miss);
      check("sat_hit_cnt", s_hit_cnt, m_s_hit);
      check("sat_miss_cnt", s_miss_cnt, m_s_miss);
      $display("txn  id=%0d hit=%0d exp_id=%0d exp_hit=%0d hit_cnt=%0d miss_cnt=%0d",
               rsp_id, rsp_hit, e[1], e[0], hit_cnt, miss_cnt);
   endtask

   task automatic a_txn(input logic [24:0] aa, input logic ea);
      txn(1'b1, aa, ea, 1'b0, 25'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 10'h0, 1'b0);
   endtask

   task automatic b_txn(input logic [24:0] ab, input logic eb);
      txn(1'b0, 25'h0, 1'b0, 1'b1, ab, eb, 1'b0, 0, 1'b0, 1'b0, 10'h0, 1'b0);
   endtask

   task automatic reset_during_resp();
      logic seen;
      @(negedge clk);
      req_a = 1'b1; addr_a = 25'h0000055; en_a = 1'b1; rsp_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (gnt_a) begin seen = 1'b1; break; end
      end
      check("rst_gnt_timeout", seen, 1);
      req_a = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin seen = 1'b1; break; end
      end
      check("rst_rsp_timeout", seen, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", rsp_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_hit_cnt", hit_cnt, 0);
      check("rst_mid_miss_cnt", miss_cnt, 0);
      model_reset();
      $display("rst  asserted during RESP valid=%0d busy=%0d", rsp_valid, busy);
      @(negedge clk);
      rst_n = 1'b1; rsp_ready = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req_a = 0; en_a = 0; addr_a = '0; req_b = 0; en_b = 0; addr_b = '0;
      rsp_ready = 1'b1; cfg_we = 0; cfg_sel = 0; cfg_limit = '0; cnt_clr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", {gnt_a, gnt_b}, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_id_hit", {rsp_id, rsp_hit}, 0);
      check("rst_cnts", {hit_cnt, miss_cnt}, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // requester A basic hits and misses
      a_txn(25'h0000055, 1'b1);
      a_txn(25'h0000054, 1'b1);
      a_txn(25'h0002055, 1'b1);
      a_txn(25'h0000100, 1'b0);
      // requester B, including ignored bits [12:10]
      b_txn(25'h000004C, 1'b1);
      b_txn(25'h000004B, 1'b1);
      b_txn(25'h0001C4C, 1'b1);
      // both requesting continuously: alternating grants
      for (int k = 0; k < 4; k++)
         txn(1'b1, 25'h0000155, 1'b1, 1'b1, 25'h000004B, 1'b1, 1'b1, 0, 1'b0, 1'b0, 10'h0, 1'b0);
      req_a = 1'b0; req_b = 1'b0;
      // consumer stalls for 10 cycles
      txn(1'b1, 25'h00003FF, 1'b1, 1'b0, 25'h0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 10'h0, 1'b0);
      // limit boundaries; a write at the capture edge must not affect that capture
      cfg_write(1'b0, 10'h000);
      a_txn(25'h0000000, 1'b1);
      txn(1'b1, 25'h0000010, 1'b1, 1'b0, 25'h0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 10'h3FF, 1'b0);
      a_txn(25'h00003FE, 1'b1);
      a_txn(25'h00003FF, 1'b1);
      cfg_write(1'b1, 10'h000);
      b_txn(25'h0000000, 1'b1);
      // reset mid-response restores the default limits
      reset_during_resp();
      a_txn(25'h0000054, 1'b1);
      a_txn(25'h0000055, 1'b1);
      b_txn(25'h000004B, 1'b1);
      b_txn(25'h000004C, 1'b1);
      // push the narrow twin into saturation, then clear against an increment
      for (int k = 0; k < 3; k++) a_txn(25'h0000155, 1'b1);
      txn(1'b1, 25'h0000155, 1'b1, 1'b0, 25'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 10'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/addr_qual_arbiter.md
Name: addr_qual_arbiter

Overview:
- Shares one address-qualification checker between two requesters, A and B.
- The checker computes: hit = en & (addr upper field == 0) & (addr index field not in the excluded low range [0, LIMIT-1]).
- This replaces the wide chained-inequality decode with a single registered compare, sequenced by a round-robin arbiter and a small FSM.
- Results return over a valid/ready response channel; hit and miss statistics are kept in saturating counters.

Parameters:
- AW, 25, address width; addr[24:0] maps to byte-address bits [27:3].
- LIMIT_A_RST, 10'h055, reset value of requester A's exclusion limit.
- LIMIT_B_RST, 10'h04C, reset value of requester B's exclusion limit.
- CW, 16, statistics counter width.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_a  in  1  requester A request; held until gnt_a.
- addr_a  in  AW  requester A address; stable while req_a is high.
- en_a  in  1  requester A qualifier enable; stable while req_a is high.
- gnt_a  out  1  one-cycle grant pulse to A.
- req_b, addr_b, en_b, gnt_b  same as the A ports, for requester B.
- rsp_valid  out  1  response valid.
- rsp_id  out  1  0 = response for A, 1 = response for B.
- rsp_hit  out  1  qualification result.
- rsp_ready  in  1  consumer accepts the response.
- cfg_we  in  1  limit register write strobe.
- cfg_sel  in  1  0 = LIMIT_A, 1 = LIMIT_B.
- cfg_limit  in  10  limit value to write.
- cnt_clr  in  1  synchronous clear of both counters.
- hit_cnt  out  CW  saturating count of hit responses.
- miss_cnt  out  CW  saturating count of miss responses.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; gnt_a=gnt_b=0; rsp_valid=rsp_id=rsp_hit=0.
  - hit_cnt=miss_cnt=0; rr_ptr=0 (A favoured); limits = *_RST values.
  - An in-flight request or pending response is dropped and never reported.
- FSM states: IDLE, CHECK, RESP.
- IDLE:
  - At an edge with req_a|req_b, select the winner.
  - If only one request is asserted, that requester wins.
  - If both are asserted, the winner is A when rr_ptr=0, else B.
  - Capture the winner's addr, en, current limit and id into internal registers.
  - Next state CHECK; the winner's gnt goes high for that one cycle.
  - With no request, stay in IDLE.
- CHECK:
  - Registered compare: hit = en_q & (addr_q[24:13]==12'h000) & (addr_q[9:0] >= limit_q).
  - addr_q[12:10] is ignored by the compare.
  - Compare is unsigned, 10 bits. limit_q=0 means no index is excluded; limit_q=10'h3FF passes only index 10'h3FF.
  - Load rsp_hit and rsp_id, set rsp_valid=1, go to RESP.
  - gnt drops to 0.
- RESP:
  - rsp_valid, rsp_id and rsp_hit are held stable until an edge with rsp_ready=1.
  - At that edge: rsp_valid returns to 0, state goes to IDLE, and rr_ptr becomes ~id_q (the other requester is favoured next).
  - The same edge increments hit_cnt if rsp_hit, else miss_cnt.
- Counters:
  - Saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle.
- Latency: request seen at edge N → gnt during cycle N+1 → rsp_valid from edge N+2. Minimum 3 cycles per transaction.
- Requesters drop req after seeing gnt. A req still high on return to IDLE is treated as a new request.
- Config:
  - cfg_we writes the selected limit at any edge.
  - A limit written in the same edge as a grant capture is not used: the old value is captured.
  - In-flight transactions keep their captured limit_q.
- Unsupported: req on a non-winning port may stay asserted indefinitely and is serviced by the round-robin pointer. No starvation: each port is served within 2 transactions.

Test Plan:
- Reset, then req_a with addr_a=25'h0000055, en_a=1 → gnt_a pulse at cycle N+1; rsp_valid, rsp_id=0, rsp_hit=1 at N+2; hit_cnt=1 after rsp_ready.
- req_a, addr_a=25'h0000054, en_a=1 → rsp_hit=0; repeat with addr_a=25'h0002055 (bit 13 set) → rsp_hit=0; en_a=0 with addr_a=25'h0000100 → rsp_hit=0. miss_cnt=3.
- req_b, addr_b=25'h000004C → hit; addr_b=25'h000004B → miss; addr_b=25'h0001C4C (bits [12:10] set) → hit.
- req_a and req_b held together for 4 transactions → grant order A,B,A,B; rsp_id sequence 0,1,0,1.
- rsp_ready held low 10 cycles → rsp_valid, rsp_id and rsp_hit stable; no new gnt; busy=1 throughout.
- cfg_we, cfg_sel=0, cfg_limit=10'h000 → addr_a=25'h0000000 with en_a=1 → hit.
- Assert rst_n=0 during RESP → rsp_valid=0 and limits restored to 10'h055 and 10'h04C immediately.
- Force hit_cnt to 16'hFFFF, then one hit response → hit_cnt stays 16'hFFFF. Assert cnt_clr together with an increment → hit_cnt=0.
